// File: rtl/id_ex_pipe_reg.sv
// ID/EX elastic stage register with optional skid slot.
// Falling-edge state, async active-low reset, flush squashes to bubbles.
module id_ex_pipe_reg #(
  parameter int unsigned CTRL_W = 9,
  parameter int unsigned PAYLOAD_W = 147,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter bit SKID_EN = 1'b1,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [CTRL_W-1:0]    in_ctrl_i,
  input  logic [PAYLOAD_W-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [CTRL_W-1:0]    out_ctrl_o,
  output logic [PAYLOAD_W-1:0] out_data_o,
  output logic [1:0]           occupancy_o,
  output logic [CNT_W-1:0]     squash_cnt_o
);

  logic                 r_m_valid;
  logic [CTRL_W-1:0]    r_m_ctrl;
  logic [PAYLOAD_W-1:0] r_m_data;
  logic                 r_s_valid;
  logic [CTRL_W-1:0]    r_s_ctrl;
  logic [PAYLOAD_W-1:0] r_s_data;
  logic [CNT_W-1:0]     r_squash_cnt;

  logic                 w_accept;
  logic                 w_drain;
  logic                 w_m_valid_d;
  logic [CTRL_W-1:0]    w_m_ctrl_d;
  logic [PAYLOAD_W-1:0] w_m_data_d;
  logic                 w_s_valid_d;
  logic [CTRL_W-1:0]    w_s_ctrl_d;
  logic [PAYLOAD_W-1:0] w_s_data_d;
  logic [1:0]           w_squash;
  logic [CNT_W:0]       w_cnt_sum;
  logic [CNT_W-1:0]     w_cnt_d;

  // Ready: registered (skid full flag) or combinational pass-through.
  generate
    if (SKID_EN) begin : g_skid_rdy
      assign in_ready_o = ~r_s_valid;
    end else begin : g_flat_rdy
      assign in_ready_o = ~r_m_valid | out_ready_i;
    end
  endgenerate

  assign w_accept = in_valid_i & in_ready_o;
  assign w_drain  = r_m_valid & out_ready_i;

  assign out_valid_o  = r_m_valid;
  assign out_ctrl_o   = r_m_valid ? r_m_ctrl : BUBBLE_CTRL;
  assign out_data_o   = r_m_data;
  assign occupancy_o  = {1'b0, r_m_valid} + {1'b0, r_s_valid};
  assign squash_cnt_o = r_squash_cnt;

  // Entries lost to a flush: undrained M, held S, and a same-edge accept.
  assign w_squash = {1'b0, r_m_valid & ~w_drain}
                  + {1'b0, r_s_valid}
                  + {1'b0, w_accept};

  assign w_cnt_sum = {1'b0, r_squash_cnt}
                   + {{(CNT_W-1){1'b0}}, w_squash};

  // Saturating squash counter next value.
  always_comb begin
    w_cnt_d = r_squash_cnt;
    if (flush_i) begin
      w_cnt_d = w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
    end
  end

  // Slot next-state: flush wins, then drain/accept movement.
  always_comb begin
    w_m_valid_d = r_m_valid;
    w_m_ctrl_d  = r_m_ctrl;
    w_m_data_d  = r_m_data;
    w_s_valid_d = r_s_valid;
    w_s_ctrl_d  = r_s_ctrl;
    w_s_data_d  = r_s_data;
    if (flush_i) begin
      w_m_valid_d = 1'b0;
      w_s_valid_d = 1'b0;
    end else if (SKID_EN) begin
      unique case (1'b1)
        (w_drain & r_s_valid): begin
          w_m_valid_d = 1'b1;
          w_m_ctrl_d  = r_s_ctrl;
          w_m_data_d  = r_s_data;
          w_s_valid_d = 1'b0;
        end
        (w_drain & ~r_s_valid): begin
          w_m_valid_d = w_accept;
          if (w_accept) begin
            w_m_ctrl_d = in_ctrl_i;
            w_m_data_d = in_data_i;
          end
        end
        (~w_drain & r_m_valid): begin
          if (w_accept) begin
            w_s_valid_d = 1'b1;
            w_s_ctrl_d  = in_ctrl_i;
            w_s_data_d  = in_data_i;
          end
        end
        (~r_m_valid): begin
          if (w_accept) begin
            w_m_valid_d = 1'b1;
            w_m_ctrl_d  = in_ctrl_i;
            w_m_data_d  = in_data_i;
          end
        end
        default: begin
          w_m_valid_d = r_m_valid;
        end
      endcase
    end else begin
      if (w_accept) begin
        w_m_valid_d = 1'b1;
        w_m_ctrl_d  = in_ctrl_i;
        w_m_data_d  = in_data_i;
      end else if (w_drain) begin
        w_m_valid_d = 1'b0;
      end
    end
  end

  // Stage state on the falling edge; reset empties both slots.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_m_valid    <= 1'b0;
      r_m_ctrl     <= BUBBLE_CTRL;
      r_m_data     <= '0;
      r_s_valid    <= 1'b0;
      r_s_ctrl     <= BUBBLE_CTRL;
      r_s_data     <= '0;
      r_squash_cnt <= '0;
    end else begin
      r_m_valid    <= w_m_valid_d;
      r_m_ctrl     <= w_m_ctrl_d;
      r_m_data     <= w_m_data_d;
      r_s_valid    <= w_s_valid_d;
      r_s_ctrl     <= w_s_ctrl_d;
      r_s_data     <= w_s_data_d;
      r_squash_cnt <= w_cnt_d;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: three configs on shared stimulus,
// checked against a queue-style model plus a directed table.
module tb_id_ex_pipe_reg;

  localparam int CW = 9;
  localparam int PW = 147;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [PW-1:0] data;
  } ent_t;

  typedef struct {
    bit            fl;
    bit            iv;
    bit            orr;
    logic [CW-1:0] ctrl;
    logic [PW-1:0] data;
    bit            e_ov;
    logic [CW-1:0] e_ctrl;
    logic [PW-1:0] e_data;
    bit            e_ir;
    int            e_occ;
    int            e_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [PW-1:0] in_data = '0;

  logic ir0, ov0, ir1, ov1, ir2, ov2;
  logic [CW-1:0] oc0, oc1, oc2;
  logic [PW-1:0] od0, od1, od2;
  logic [1:0] occ0, occ1, occ2;
  logic [15:0] cn0, cn1;
  logic [3:0] cn2;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.SKID_EN(1'b1), .CNT_W(16)) u_skid (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(ir0),
    .in_ctrl_i(in_ctrl), .in_data_i(in_data),
    .out_valid_o(ov0), .out_ready_i(out_ready),
    .out_ctrl_o(oc0), .out_data_o(od0),
    .occupancy_o(occ0), .squash_cnt_o(cn0));

  id_ex_pipe_reg #(.SKID_EN(1'b0), .CNT_W(16)) u_flat (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(ir1),
    .in_ctrl_i(in_ctrl), .in_data_i(in_data),
    .out_valid_o(ov1), .out_ready_i(out_ready),
    .out_ctrl_o(oc1), .out_data_o(od1),
    .occupancy_o(occ1), .squash_cnt_o(cn1));

  id_ex_pipe_reg #(.SKID_EN(1'b1), .CNT_W(4)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(ir2),
    .in_ctrl_i(in_ctrl), .in_data_i(in_data),
    .out_valid_o(ov2), .out_ready_i(out_ready),
    .out_ctrl_o(oc2), .out_data_o(od2),
    .occupancy_o(occ2), .squash_cnt_o(cn2));

  int nvec = 0;
  int nmis = 0;

  // Reference model: per config an ordered list of held entries.
  ent_t          mb[3][2];
  int            mn[3];
  logic [PW-1:0] ml[3];
  int            ms[3];
  int            cmax[3];
  bit            skid[3];
  bit            rdy[3];
  bit            acc[3];

  vec_t tab[17];
  bit   use_tab;
  vec_t cur;

  task automatic chk(string nm, logic [PW-1:0] act, logic [PW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit m_rdy(int i);
    if (skid[i]) return mn[i] < 2;
    return (mn[i] == 0) || out_ready;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      mn[i] = 0;
      ml[i] = '0;
      ms[i] = 0;
    end
  endtask

  task automatic m_edge(int i);
    bit d;
    int sq;
    acc[i] = in_valid && rdy[i];
    d = (mn[i] > 0) && out_ready;
    if (flush) begin
      sq = mn[i] - int'(d) + int'(acc[i]);
      mn[i] = 0;
      ms[i] = (ms[i] + sq > cmax[i]) ? cmax[i] : ms[i] + sq;
    end else begin
      if (d) begin
        mb[i][0] = mb[i][1];
        mn[i]--;
      end
      if (acc[i]) begin
        mb[i][mn[i]].ctrl = in_ctrl;
        mb[i][mn[i]].data = in_data;
        mn[i]++;
      end
      if (mn[i] > 0) ml[i] = mb[i][0].data;
    end
  endtask

  task automatic check_model();
    logic a_ov, a_ir;
    logic [CW-1:0] a_oc, e_oc;
    logic [PW-1:0] a_od;
    logic [1:0] a_occ;
    logic [15:0] a_cn;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin a_ov = ov0; a_ir = ir0; a_oc = oc0; a_od = od0;
                 a_occ = occ0; a_cn = cn0; end
        1: begin a_ov = ov1; a_ir = ir1; a_oc = oc1; a_od = od1;
                 a_occ = occ1; a_cn = cn1; end
        default: begin a_ov = ov2; a_ir = ir2; a_oc = oc2; a_od = od2;
                 a_occ = occ2; a_cn = {12'd0, cn2}; end
      endcase
      e_oc = (mn[i] > 0) ? mb[i][0].ctrl : '0;
      chk($sformatf("dut%0d.out_valid", i), PW'(a_ov), PW'(mn[i] > 0));
      chk($sformatf("dut%0d.in_ready", i), PW'(a_ir), PW'(m_rdy(i)));
      chk($sformatf("dut%0d.out_ctrl", i), PW'(a_oc), PW'(e_oc));
      chk($sformatf("dut%0d.out_data", i), a_od, ml[i]);
      chk($sformatf("dut%0d.occupancy", i), PW'(a_occ), PW'(mn[i]));
      chk($sformatf("dut%0d.squash_cnt", i), PW'(a_cn), PW'(ms[i]));
    end
  endtask

  task automatic check_tab();
    chk("tab.out_valid", PW'(ov0), PW'(cur.e_ov));
    chk("tab.out_ctrl", PW'(oc0), PW'(cur.e_ctrl));
    chk("tab.out_data", od0, cur.e_data);
    chk("tab.in_ready", PW'(ir0), PW'(cur.e_ir));
    chk("tab.occupancy", PW'(occ0), PW'(cur.e_occ));
    chk("tab.squash_cnt", PW'(cn0), PW'(cur.e_cnt));
  endtask

  // One cycle: drive after the falling edge, sample at the rising edge.
  task automatic step(bit fl, bit iv, bit orr,
                      logic [CW-1:0] c, logic [PW-1:0] d);
    flush = fl;
    in_valid = iv;
    out_ready = orr;
    in_ctrl = c;
    in_data = d;
    @(posedge clk);
    check_model();
    if (use_tab) check_tab();
    for (int i = 0; i < 3; i++) rdy[i] = m_rdy(i);
    @(negedge clk);
    for (int i = 0; i < 3; i++) m_edge(i);
    #1;
  endtask

  task automatic do_reset();
    flush = 0;
    in_valid = 0;
    out_ready = 0;
    #2;
    rst_n = 0;
    m_reset();
    #1;
    check_model();
    @(negedge clk);
    #1;
    rst_n = 1;
  endtask

  function automatic logic [CW-1:0] lc(int l);
    case (l)
      1: return 9'h0A5;
      2: return 9'h0B6;
      3: return 9'h0C7;
      default: return '0;
    endcase
  endfunction

  function automatic logic [PW-1:0] ld(int l);
    case (l)
      1: return PW'(32'hA);
      2: return PW'(32'hB);
      3: return PW'(32'hC);
      default: return '0;
    endcase
  endfunction

  function automatic vec_t mkv(bit fl, bit iv, bit orr, int l, bit eov,
                               int el, int edl, bit eir, int eocc, int ecnt);
    vec_t v;
    v.fl = fl; v.iv = iv; v.orr = orr;
    v.ctrl = lc(l); v.data = ld(l);
    v.e_ov = eov;
    v.e_ctrl = eov ? lc(el) : '0;
    v.e_data = ld(edl);
    v.e_ir = eir; v.e_occ = eocc; v.e_cnt = ecnt;
    return v;
  endfunction

  function automatic logic [PW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int k;
    int budget;
    skid = '{1'b1, 1'b0, 1'b1};
    cmax = '{65535, 65535, 15};
    use_tab = 0;
    m_reset();

    tab[0]  = mkv(0,1,0,1, 0,0,0, 1,0,0);
    tab[1]  = mkv(0,1,0,2, 1,1,1, 1,1,0);
    tab[2]  = mkv(0,1,0,3, 1,1,1, 0,2,0);
    tab[3]  = mkv(0,1,1,3, 1,1,1, 0,2,0);
    tab[4]  = mkv(0,1,1,3, 1,2,2, 1,1,0);
    tab[5]  = mkv(0,0,1,0, 1,3,3, 1,1,0);
    tab[6]  = mkv(0,0,0,0, 0,0,3, 1,0,0);
    tab[7]  = mkv(0,1,0,1, 0,0,3, 1,0,0);
    tab[8]  = mkv(0,1,0,2, 1,1,1, 1,1,0);
    tab[9]  = mkv(1,1,0,3, 1,1,1, 0,2,0);
    tab[10] = mkv(0,0,0,0, 0,0,1, 1,0,2);
    tab[11] = mkv(0,1,0,1, 0,0,1, 1,0,2);
    tab[12] = mkv(1,1,0,3, 1,1,1, 1,1,2);
    tab[13] = mkv(0,0,0,0, 0,0,1, 1,0,4);
    tab[14] = mkv(0,1,0,1, 0,0,1, 1,0,4);
    tab[15] = mkv(1,0,1,0, 1,1,1, 1,1,4);
    tab[16] = mkv(0,0,0,0, 0,0,1, 1,0,4);

    #2;
    check_model();
    @(negedge clk);
    #1;
    rst_n = 1;

    // Backpressure, skid ordering and flush cases.
    use_tab = 1;
    for (int r = 0; r < 17; r++) begin
      cur = tab[r];
      step(cur.fl, cur.iv, cur.orr, cur.ctrl, cur.data);
    end
    use_tab = 0;

    // Continuous stream through the skid config.
    do_reset();
    k = 0;
    budget = 0;
    while (k < 10 && budget < 40) begin
      step(0, 1, 1, 9'h1A5, PW'(k));
      if (acc[0]) k++;
      budget++;
    end
    chk("stream.accepted", PW'(k), PW'(10));
    for (int i = 0; i < 3; i++) step(0, 0, 1, '0, '0);

    // Flat config with out_ready toggling every cycle.
    do_reset();
    k = 0;
    budget = 0;
    while (k < 20 && budget < 80) begin
      step(0, 1, budget[0], 9'h055, PW'(100 + k));
      if (acc[1]) k++;
      budget++;
    end
    chk("flat.accepted", PW'(k), PW'(20));
    for (int i = 0; i < 4; i++) step(0, 0, 1, '0, '0);

    // Eighteen squashed accepts saturate the 4-bit counter.
    do_reset();
    for (int i = 0; i < 18; i++) step(1, 1, 0, 9'h011, PW'(i));
    step(0, 0, 0, '0, '0);
    chk("sat.cnt4", PW'(cn2), PW'(4'hF));
    chk("sat.cnt16", PW'(cn0), PW'(18));

    // Randomised traffic.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 16) == 0, ($urandom % 4) != 0,
           ($urandom % 3) != 0, CW'($urandom), rnd_data());
    end

    // Asynchronous reset between edges with entries held.
    step(0, 1, 0, 9'h0AA, PW'(77));
    step(0, 1, 0, 9'h0BB, PW'(88));
    step(1, 1, 0, 9'h0CC, PW'(99));
    step(0, 1, 0, 9'h0DD, PW'(55));
    #2;
    rst_n = 0;
    #1;
    chk("arst.out_valid", PW'(ov0), PW'(0));
    chk("arst.out_ctrl", PW'(oc0), PW'(0));
    chk("arst.out_data", od0, '0);
    chk("arst.occupancy", PW'(occ0), PW'(0));
    chk("arst.squash_cnt", PW'(cn0), PW'(0));
    chk("arst.in_ready", PW'(ir0), PW'(1));
    m_reset();
    check_model();
    @(negedge clk);
    #1;
    rst_n = 1;
    step(0, 0, 0, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
